// File: rtl/lcd_write_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_write_arbiter
//
// Purpose: shares the single lcd_interface write port between two write
// requesters. Arbitration is round-robin. The owner keeps the port for its
// whole burst. The burst length is bounded so that a waiting requester is
// never starved. Every output that goes to lcd_interface is registered.
//
// Handshake: a requester raises ReqN and holds it for the whole burst. It
// owns the port while GntN=1. A write beat is accepted in any cycle where
// GntN=1 and Wr_EnN=1. That beat shows up on Write_* at the next edge.
// Beats from the requester that does not hold the grant are dropped.
//
// Ports:
//   CLOCK, RST                       clock, synchronous active-high reset
//   Req0/Wr_En0/Addr0/Data0, Gnt0    requester 0 request, beat, grant
//   Req1/Wr_En1/Addr1/Data1, Gnt1    requester 1 request, beat, grant
//   Write_En_Sig/Addr_Sig/Data       registered write port to lcd_interface
//   Busy                             Gnt0|Gnt1
//   Stat_Cnt0/Stat_Cnt1              accepted-beat counters (16-bit, wrap)
//
// Optional feature: define LCD_ARB_STAT_EN to build the Stat_Cnt counters.
// When the macro is undefined, both outputs are tied to zero.
// ---------------------------------------------------------------------------
module lcd_write_arbiter #(
    parameter int MAX_BURST = 128,
    parameter int AW        = 10,
    parameter int DW        = 8
) (
    input  logic          CLOCK,
    input  logic          RST,
    input  logic          Req0,
    input  logic          Wr_En0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] Data0,
    output logic          Gnt0,
    input  logic          Req1,
    input  logic          Wr_En1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Data1,
    output logic          Gnt1,
    output logic          Write_En_Sig,
    output logic [AW-1:0] Write_Addr_Sig,
    output logic [DW-1:0] Write_Data,
    output logic          Busy,
    output logic [15:0]   Stat_Cnt0,
    output logic [15:0]   Stat_Cnt1
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;       // id of the requester served last
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_gnt0, r_gnt1;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_acc0, w_acc1;

    assign w_acc0 = r_gnt0 & Wr_En0;
    assign w_acc1 = r_gnt1 & Wr_En1;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = r_cnt + CW'(1);
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                // On a tie the grant goes to the requester that was not served last.
                if (Req0 && Req1)  w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                else if (Req0)     w_state_nxt = ST_OWN0;
                else if (Req1)     w_state_nxt = ST_OWN1;
            end
            ST_OWN0: begin
                if (w_acc0) w_cnt_nxt = w_cnt_inc;
                if (!Req0) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_acc0 && (w_cnt_inc == BURST_MAX)) begin
                    // A full burst is done. Hand over only if the other
                    // requester is waiting; otherwise start a new burst window.
                    w_cnt_nxt = '0;
                    if (Req1) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            ST_OWN1: begin
                if (w_acc1) w_cnt_nxt = w_cnt_inc;
                if (!Req1) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_acc1 && (w_cnt_inc == BURST_MAX)) begin
                    w_cnt_nxt = '0;
                    if (Req0) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            // Grants are registered copies of the next state.
            r_gnt0  <= (w_state_nxt == ST_OWN0);
            r_gnt1  <= (w_state_nxt == ST_OWN1);
            r_wen   <= w_acc0 | w_acc1;
            if (w_acc0) begin
                r_addr <= Addr0;
                r_data <= Data0;
            end else if (w_acc1) begin
                r_addr <= Addr1;
                r_data <= Data1;
            end
        end
    end

    assign Gnt0           = r_gnt0;
    assign Gnt1           = r_gnt1;
    assign Busy           = r_gnt0 | r_gnt1;
    assign Write_En_Sig   = r_wen;
    assign Write_Addr_Sig = r_addr;
    assign Write_Data     = r_data;

`ifdef LCD_ARB_STAT_EN
    logic [15:0] r_stat0, r_stat1;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (w_acc0) r_stat0 <= r_stat0 + 16'd1;
            if (w_acc1) r_stat1 <= r_stat1 + 16'd1;
        end
    end

    assign Stat_Cnt0 = r_stat0;
    assign Stat_Cnt1 = r_stat1;
`else
    assign Stat_Cnt0 = '0;
    assign Stat_Cnt1 = '0;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
module tb_lcd_write_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int W  = AW + DW;

    logic          CLOCK;
    logic          RST;
    logic          Req0, Wr_En0, Req1, Wr_En1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] Data0, Data1;
    logic          Gnt0, Gnt1, Write_En_Sig, Busy;
    logic [AW-1:0] Write_Addr_Sig;
    logic [DW-1:0] Write_Data;
    logic [15:0]   Stat_Cnt0, Stat_Cnt1;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          rst;
        logic          q0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          q1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          e_g0;
        logic          e_g1;
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [15:0]   e_s0;
        logic [15:0]   e_s1;
    } vec_t;

    vec_t vecs[$];

    lcd_write_arbiter #(.MAX_BURST(8), .AW(AW), .DW(DW)) dut (
        .CLOCK(CLOCK), .RST(RST),
        .Req0(Req0), .Wr_En0(Wr_En0), .Addr0(Addr0), .Data0(Data0), .Gnt0(Gnt0),
        .Req1(Req1), .Wr_En1(Wr_En1), .Addr1(Addr1), .Data1(Data1), .Gnt1(Gnt1),
        .Write_En_Sig(Write_En_Sig), .Write_Addr_Sig(Write_Addr_Sig),
        .Write_Data(Write_Data), .Busy(Busy),
        .Stat_Cnt0(Stat_Cnt0), .Stat_Cnt1(Stat_Cnt1)
    );

    // ---------------- clock / reset ----------------
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic q0, input logic w0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic q1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        RST = rst; Req0 = q0; Wr_En0 = w0; Addr0 = a0; Data0 = d0;
        Req1 = q1; Wr_En1 = w1; Addr1 = a1; Data1 = d1;
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] v);
`ifdef LCD_ARB_STAT_EN
        return v;
`else
        return 16'd0;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic sb_observe(input string name);
        logic [W-1:0] exp_v;
        if (Write_En_Sig) begin
            if (exp_q.size() == 0) begin
                chk({name, " unexpected write"}, {14'd0, Write_Addr_Sig, Write_Data}, 32'hFFFF_FFFF);
            end else begin
                exp_v = exp_q.pop_front();
                chk({name, " addr/data"}, {14'd0, Write_Addr_Sig, Write_Data}, {14'd0, exp_v});
            end
        end
    endtask

    task automatic sb_drain(input string name);
        chk({name, " pending writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic add(input logic rst, input logic q0, input logic w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic g0, input logic g1, input logic wen,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input logic [15:0] s0, input logic [15:0] s1);
        vec_t v;
        v = '{rst, q0, w0, a0, d0, q1, w1, a1, d1, g0, g1, wen, ea, ed, s0, s1};
        vecs.push_back(v);
    endtask

    initial begin
        drive(1, 0, 0, '0, '0, 0, 0, '0, '0);

        // ---- vector table: reset, tie/handoff, release beat, single burst ----
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 1, 10'(i), 8'(8'hA0 + i), 1, 1, 10'(10'h3F0 + i), 8'h50,
                1, 0, 1, 10'(i), 8'(8'hA0 + i), 16'(i + 1), 0);
        add(0, 0, 0, 0, 0, 1, 1, 10'h3F5, 8'h55,   0, 0, 0, 10'h4, 8'hA4, 5, 0);
        add(0, 0, 0, 0, 0, 1, 1, 10'h3F6, 8'h56,   0, 1, 0, 10'h4, 8'hA4, 5, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 0, 1, 1, 10'(10'h100 + i), 8'(8'h10 + i),
                0, 1, 1, 10'(10'h100 + i), 8'(8'h10 + i), 5, 16'(i + 1));
        add(0, 0, 0, 0, 0, 0, 1, 10'h1FF, 8'h77,   0, 0, 1, 10'h1FF, 8'h77, 5, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 10'h1FF, 8'h77, 5, 4);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0,             1, 0, 0, 10'h1FF, 8'h77, 5, 4);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 10'(i), 8'(8'hA0 + i), 0, 0, 0, 0,
                1, 0, 1, 10'(i), 8'(8'hA0 + i), 16'(6 + i), 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 10'h3, 8'hA3, 9, 4);
        add(0, 0, 1, 10'h2AA, 8'h11, 0, 0, 0, 0,   0, 0, 0, 10'h3, 8'hA3, 9, 4);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].q0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            step();
            chk($sformatf("vec%0d gnt0", i), Gnt0, vecs[i].e_g0);
            chk($sformatf("vec%0d gnt1", i), Gnt1, vecs[i].e_g1);
            chk($sformatf("vec%0d busy", i), Busy, vecs[i].e_g0 | vecs[i].e_g1);
            chk($sformatf("vec%0d wen", i), Write_En_Sig, vecs[i].e_wen);
            chk($sformatf("vec%0d addr", i), Write_Addr_Sig, vecs[i].e_addr);
            chk($sformatf("vec%0d data", i), Write_Data, vecs[i].e_data);
            chk($sformatf("vec%0d stat0", i), Stat_Cnt0, sx(vecs[i].e_s0));
            chk($sformatf("vec%0d stat1", i), Stat_Cnt1, sx(vecs[i].e_s1));
        end

        // ---- preemption with MAX_BURST=8: both requesters stream ----
        drive(1, 1, 1, 0, 0, 1, 1, 0, 0);
        step();
        chk("pre rst gnt", {Gnt0, Gnt1, Write_En_Sig}, 0);
        chk("pre rst stat", {Stat_Cnt0, Stat_Cnt1}, 0);
        for (int e = 1; e <= 36; e++) begin
            int ph;
            int own;
            ph  = (e - 1) % 9;
            own = ((e - 1) / 9) % 2;
            drive(0, 1, 1, 10'(e), 8'(e), 1, 1, 10'(10'h200 + e), 8'(8'h80 + e));
            if (ph != 0)
                exp_q.push_back(own ? {10'(10'h200 + e), 8'(8'h80 + e)} : {10'(e), 8'(e)});
            step();
            chk($sformatf("pre e%0d gnt0", e), Gnt0, (ph != 8) && (own == 0));
            chk($sformatf("pre e%0d gnt1", e), Gnt1, (ph != 8) && (own == 1));
            chk($sformatf("pre e%0d busy", e), Busy, ph != 8);
            chk($sformatf("pre e%0d wen", e), Write_En_Sig, ph != 0);
            sb_observe($sformatf("pre e%0d", e));
        end
        sb_drain("pre");
        chk("pre stat0", Stat_Cnt0, sx(16));
        chk("pre stat1", Stat_Cnt1, sx(16));

        // ---- requester 1 quiet: requester 0 keeps the port for 20 beats ----
        drive(0, 1, 1, 10'h3C0, 8'h3C, 0, 0, 0, 0);
        step();
        chk("solo grant gnt0", Gnt0, 1);
        chk("solo grant wen", Write_En_Sig, 0);
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 1, 10'(38 + k), 8'(38 + k), 0, 0, 0, 0);
            exp_q.push_back({10'(38 + k), 8'(38 + k)});
            step();
            chk($sformatf("solo k%0d gnt0", k), Gnt0, 1);
            chk($sformatf("solo k%0d wen", k), Write_En_Sig, 1);
            sb_observe($sformatf("solo k%0d", k));
        end
        sb_drain("solo");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("solo release gnt0", Gnt0, 0);
        chk("solo stat0", Stat_Cnt0, sx(36));

        // ---- non-owner write is ignored ----
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("nonown gnt0", Gnt0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 0, 0, 1, 10'h3FF, 8'hFF);
            step();
            chk($sformatf("nonown k%0d gnt1", k), Gnt1, 0);
            chk($sformatf("nonown k%0d wen", k), Write_En_Sig, 0);
            chk($sformatf("nonown k%0d addr", k), Write_Addr_Sig, 10'd57);
            chk($sformatf("nonown k%0d stat1", k), Stat_Cnt1, sx(16));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("nonown release", Gnt0, 0);

        // ---- reset during requester 1's third beat ----
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("mid gnt1", Gnt1, 1);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, 1, 1, 10'(10'h120 + k), 8'(8'hC0 + k));
            step();
            chk($sformatf("mid beat%0d wen", k), Write_En_Sig, 1);
            chk($sformatf("mid beat%0d addr", k), Write_Addr_Sig, 10'(10'h120 + k));
            chk($sformatf("mid beat%0d stat1", k), Stat_Cnt1, sx(16'(17 + k)));
        end
        drive(1, 0, 0, 0, 0, 1, 1, 10'h122, 8'hC2);
        step();
        chk("mid rst grants", {Gnt0, Gnt1, Busy}, 0);
        chk("mid rst wen", Write_En_Sig, 0);
        chk("mid rst addr", Write_Addr_Sig, 0);
        chk("mid rst data", Write_Data, 0);
        chk("mid rst stats", {Stat_Cnt0, Stat_Cnt1}, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
        step();
        chk("post rst gnt0", Gnt0, 1);
        chk("post rst gnt1", Gnt1, 0);
        chk("post rst stats", {Stat_Cnt0, Stat_Cnt1}, 0);

        // ---- final report ----
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
